mux_rr_arbiter: RTL and testbench
=================================

Name: mux_rr_arbiter

Overview:
Round-robin arbiter that shares one 16-bit output channel among four requesters (A, B, C, D). It picks a requester, drives the 2-bit select code into the 4:1 mux datapath and captures the selected word into an output register. It then presents that word to a single downstream consumer through a valid/ready handshake. It sits between the four data sources and the shared consumer, and it owns the mux select.

Parameters:
WIDTH, 16, data width of each source and of the output word
NREQ, 4, number of requesters; fixed at 4, matching the 2-bit select

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
req  in  4  request per source; bit0=A, bit1=B, bit2=C, bit3=D; held high with data stable until granted
A  in  WIDTH  source 0 data
B  in  WIDTH  source 1 data
C  in  WIDTH  source 2 data
D  in  WIDTH  source 3 data
gnt  out  4  one-hot, one-cycle pulse: the word of that source is captured this cycle
Select  out  2  registered select code of the current/last grant (00=A, 01=B, 10=C, 11=D)
out_data  out  WIDTH  registered output word
out_valid  out  1  out_data holds an unconsumed word
out_ready  in  1  consumer accepts out_data when out_valid&&out_ready at a rising edge

Behaviour:
- Reset (rst=1 at a rising edge, highest priority): state=IDLE, gnt=0, Select=2'b11, out_data=0, out_valid=0, internal last-grant pointer=3. The first grant after reset therefore favours A.
- Load condition: load = (state==IDLE) || (out_valid && out_ready).
- Arbitration (combinational), evaluated only when load=1 and |req=1:
  - Search order is last+1, last+2, last+3, last, all mod 4.
  - The first set req bit wins.
  - The last-granted source gets lowest priority, which prevents starvation.
- Grant cycle, at the edge where load && |req:
  - out_data <= word of the winner.
  - Select <= winner; last <= winner.
  - out_valid <= 1; state <= BUSY.
  - gnt[winner]=1 is registered, so it is visible in the cycle after the capture edge, for exactly one cycle.
- Requester handshake:
  - A requester may drop req, or present a new word, in the cycle gnt is high.
  - If it still shows req in that cycle, that counts as a new request.
  - The arbiter must not double-capture. A source whose gnt is high is masked from arbitration in that cycle.
- States:
  - IDLE: out_valid=0. Moves to BUSY on a grant; otherwise stays.
  - BUSY: out_valid=1, out_data stable. While out_ready=0, hold everything and issue no grant.
  - BUSY with out_ready=1 and an eligible request: capture the next winner in the same edge, stay in BUSY. This gives back-to-back throughput of 1 word/cycle.
  - BUSY with out_ready=1 and no eligible request: out_valid <= 0, state <= IDLE. out_data and Select hold their last values.
- Latency: req rising while IDLE gives out_valid=1 and gnt pulse 1 cycle later.
- Boundary conditions:
  - All four req high continuously with out_ready=1: grants cycle A,B,C,D,A...
  - A single requester held high with out_ready=1 is granted every other cycle, because of gnt masking.
  - out_ready high while out_valid=0 is ignored.
  - Reset mid-transfer drops the pending word silently and emits no gnt.
- Exactly one gnt bit is high at any time, or none.

Optional Feature:
Macro ARB_LOCK_EN.
- Defined:
  - Adds input lock[3:0].
  - If the current owner (Select) has lock[Select]=1 and req[Select]=1 at a load, that owner wins regardless of rotation, and the gnt mask for it is ignored. This allows burst transfers at 1 word/cycle.
  - The pointer is not advanced while locked.
  - Dropping lock returns to normal rotation.
- Undefined: no lock port; pure round-robin as above.

Test Plan:
1. Reset, then req=4'b0001, A=16'h1234, out_ready=1 -> 1 cycle later out_valid=1, out_data=16'h1234, Select=00, gnt=0001 for one cycle; then IDLE.
2. req=4'b1111, distinct words A=0xAAAA, B=0xBBBB, C=0xCCCC, D=0xDDDD, out_ready=1 -> out_data sequence AAAA, BBBB, CCCC, DDDD, AAAA on consecutive cycles; gnt rotates 0001, 0010, 0100, 1000.
3. Backpressure: word 0x5555 from C valid, out_ready=0 for 5 cycles while B requests -> out_data holds 0x5555, no gnt to B. When out_ready=1, B is captured at the same edge.
4. Fairness: last grant = B, then req=4'b0011 -> A wins before B.
5. Reset asserted while BUSY with out_ready=0 -> next cycle out_valid=0, out_data=0, Select=11, gnt=0.
6. ARB_LOCK_EN: B with lock[1]=1, req=4'b1111, out_ready=1 for 4 cycles -> four consecutive B grants. Drop lock -> next grants go to C, then D.

Source files
------------

// File: rtl/mux_rr_arbiter_if.sv
// ==== mux_rr_arbiter_if : requester/consumer bundle for mux_rr_arbiter ====
// ==== rev 1.0 ; lock[] present only when ARB_LOCK_EN is defined          ====
`default_nettype none

interface mux_rr_arbiter_if #(
  parameter int WIDTH = 16
);
  logic [3:0]       req;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] C;
  logic [WIDTH-1:0] D;
  logic [3:0]       gnt;
  logic [1:0]       Select;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
`ifdef ARB_LOCK_EN
  logic [3:0]       lock;

  modport master (
    input  req, A, B, C, D, out_ready, lock,
    output gnt, Select, out_data, out_valid
  );
  modport slave (
    output req, A, B, C, D, out_ready, lock,
    input  gnt, Select, out_data, out_valid
  );
`else
  modport master (
    input  req, A, B, C, D, out_ready,
    output gnt, Select, out_data, out_valid
  );
  modport slave (
    output req, A, B, C, D, out_ready,
    input  gnt, Select, out_data, out_valid
  );
`endif
endinterface

`default_nettype wire

// File: rtl/mux_rr_arbiter.sv
// ==== mux_rr_arbiter : 4-way round-robin arbiter, 4:1 mux, valid/ready output ====
// ==== rev 1.0 ; optional owner lock via ARB_LOCK_EN                            ====
`default_nettype none

module mux_rr_arbiter #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4
) (
  input  wire logic        clk,
  input  wire logic        rst,
  mux_rr_arbiter_if.master bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       last_q, last_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [WIDTH-1:0] data_q, data_d;

  logic             load_w;
  logic             lock_hit_w;
  logic             found_w;
  logic [1:0]       win_w;
  logic [1:0]       idx_w;
  logic [3:0]       elig_w;
  logic [WIDTH-1:0] win_data_w;

`ifdef ARB_LOCK_EN
  assign lock_hit_w = bus.lock[sel_q] && bus.req[sel_q];
`else
  assign lock_hit_w = 1'b0;
`endif

  assign load_w = (state_q == IDLE) || ((state_q == BUSY) && bus.out_ready);
  // The source being granted this cycle may still show req; that word is new
  // only from the next cycle on, so it is excluded here.
  assign elig_w = bus.req & ~gnt_q;

  always_comb begin
    found_w = 1'b0;
    win_w   = last_q;
    idx_w   = last_q;
    if (lock_hit_w) begin
      found_w = 1'b1;
      win_w   = sel_q;
    end else begin
      for (int i = 1; i <= NREQ; i++) begin
        idx_w = last_q + 2'(i);
        if (!found_w && elig_w[idx_w]) begin
          found_w = 1'b1;
          win_w   = idx_w;
        end
      end
    end
  end

  always_comb begin
    case (win_w)
      2'd0:    win_data_w = bus.A;
      2'd1:    win_data_w = bus.B;
      2'd2:    win_data_w = bus.C;
      default: win_data_w = bus.D;
    endcase
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = 4'b0000;
    sel_d   = sel_q;
    last_d  = last_q;
    data_d  = data_q;
    if (load_w) begin
      if (found_w) begin
        state_d = BUSY;
        data_d  = win_data_w;
        sel_d   = win_w;
        gnt_d   = 4'b0001 << win_w;
        if (!lock_hit_w) begin
          last_d = win_w;
        end
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'b11;
      last_q  <= 2'b11;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.Select    = sel_q;
  assign bus.out_data  = data_q;
  assign bus.out_valid = (state_q == BUSY);

endmodule

`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
// ==== tb_mux_rr_arbiter : directed self-checking bench for mux_rr_arbiter ====
// ==== rev 1.0 ; lock scenario compiled in when ARB_LOCK_EN is defined     ====
`default_nettype none

module tb_mux_rr_arbiter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  mux_rr_arbiter_if #(.WIDTH(16)) bus ();

  mux_rr_arbiter #(.WIDTH(16), .NREQ(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [15:0] d,
                           input logic [1:0] s, input logic [3:0] g);
    check_eq({tag, ".valid"},  32'(bus.out_valid), 32'(v));
    check_eq({tag, ".data"},   32'(bus.out_data),  32'(d));
    check_eq({tag, ".select"}, 32'(bus.Select),    32'(s));
    check_eq({tag, ".gnt"},    32'(bus.gnt),       32'(g));
  endtask

  logic [15:0] exp_data [5];
  logic [3:0]  exp_gnt  [5];

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.req       = 4'b0000;
    bus.A         = 16'h0000;
    bus.B         = 16'h0000;
    bus.C         = 16'h0000;
    bus.D         = 16'h0000;
    bus.out_ready = 1'b0;
`ifdef ARB_LOCK_EN
    bus.lock      = 4'b0000;
`endif
    tick();
    tick();
    check_out("reset", 1'b0, 16'h0000, 2'b11, 4'b0000);

    // single grant, then back to IDLE
    rst = 1'b0;
    bus.req = 4'b0001; bus.A = 16'h1234; bus.out_ready = 1'b1;
    tick();
    check_out("t1_grant", 1'b1, 16'h1234, 2'b00, 4'b0001);
    bus.req = 4'b0000;
    tick();
    check_out("t1_idle", 1'b0, 16'h1234, 2'b00, 4'b0000);
    tick();
    check_out("ready_in_idle", 1'b0, 16'h1234, 2'b00, 4'b0000);

    // single requester held: granted every other cycle
    bus.req = 4'b0001; bus.A = 16'h0A0A;
    tick();
    check_out("hold_g1", 1'b1, 16'h0A0A, 2'b00, 4'b0001);
    tick();
    check_out("hold_gap", 1'b0, 16'h0A0A, 2'b00, 4'b0000);
    tick();
    check_out("hold_g2", 1'b1, 16'h0A0A, 2'b00, 4'b0001);
    bus.req = 4'b0000;
    tick();

    // all four requesting, back-to-back rotation
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req = 4'b1111;
    bus.A = 16'hAAAA; bus.B = 16'hBBBB; bus.C = 16'hCCCC; bus.D = 16'hDDDD;
    exp_data[0] = 16'hAAAA; exp_gnt[0] = 4'b0001;
    exp_data[1] = 16'hBBBB; exp_gnt[1] = 4'b0010;
    exp_data[2] = 16'hCCCC; exp_gnt[2] = 4'b0100;
    exp_data[3] = 16'hDDDD; exp_gnt[3] = 4'b1000;
    exp_data[4] = 16'hAAAA; exp_gnt[4] = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_out($sformatf("rot%0d", i), 1'b1, exp_data[i], 2'(i % 4), exp_gnt[i]);
    end
    bus.req = 4'b0000;
    tick();

    // backpressure: C word held while B waits
    bus.out_ready = 1'b0;
    bus.req = 4'b0100; bus.C = 16'h5555;
    tick();
    check_out("bp_capture", 1'b1, 16'h5555, 2'b10, 4'b0100);
    bus.req = 4'b0010; bus.B = 16'hB0B0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_out($sformatf("bp_hold%0d", i), 1'b1, 16'h5555, 2'b10, 4'b0000);
    end
    bus.out_ready = 1'b1;
    tick();
    check_out("bp_release", 1'b1, 16'hB0B0, 2'b01, 4'b0010);

    // fairness: last grant was B, so A goes first
    bus.req = 4'b0000;
    tick();
    check_out("fair_idle", 1'b0, 16'hB0B0, 2'b01, 4'b0000);
    bus.req = 4'b0011; bus.A = 16'hA1A1; bus.B = 16'hB1B1;
    tick();
    check_out("fair_a", 1'b1, 16'hA1A1, 2'b00, 4'b0001);
    tick();
    check_out("fair_b", 1'b1, 16'hB1B1, 2'b01, 4'b0010);
    bus.req = 4'b0000;
    tick();

    // reset while BUSY and stalled
    bus.out_ready = 1'b0;
    bus.req = 4'b1000; bus.D = 16'hD00D;
    tick();
    check_out("rst_busy", 1'b1, 16'hD00D, 2'b11, 4'b1000);
    bus.req = 4'b0000;
    rst = 1'b1;
    tick();
    check_out("rst_mid", 1'b0, 16'h0000, 2'b11, 4'b0000);
    rst = 1'b0;
    tick();
    check_out("rst_after", 1'b0, 16'h0000, 2'b11, 4'b0000);

`ifdef ARB_LOCK_EN
    // B locks ownership for a burst, then rotation resumes at C
    bus.out_ready = 1'b1;
    bus.lock = 4'b0010;
    bus.req = 4'b0010;
    bus.A = 16'hAAAA; bus.B = 16'hBBBB; bus.C = 16'hCCCC; bus.D = 16'hDDDD;
    tick();
    check_out("lock_b0", 1'b1, 16'hBBBB, 2'b01, 4'b0010);
    bus.req = 4'b1111;
    for (int i = 1; i < 4; i++) begin
      tick();
      check_out($sformatf("lock_b%0d", i), 1'b1, 16'hBBBB, 2'b01, 4'b0010);
    end
    bus.lock = 4'b0000;
    tick();
    check_out("unlock_c", 1'b1, 16'hCCCC, 2'b10, 4'b0100);
    tick();
    check_out("unlock_d", 1'b1, 16'hDDDD, 2'b11, 4'b1000);
    bus.req = 4'b0000;
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
